adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one combinational WIDTH-bit adder (a, b -> out[WIDTH:0]) between NREQ requesters.
//  - Arbitrates requests, sequences operands into the adder and registers the sum.
//  - Returns each result with the winning requester's ID over a valid/ready response port.
//  - Sits between the requesting blocks and the single adder instance it drives.
// PARAMETERS
//  WIDTH  4  operand width; the adder sum is WIDTH+1 bits
//  NREQ   4  number of requesters, >=2; ID_W = $clog2(NREQ) (2 at default)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   NREQ          request i has operands pending
//  req_ready  out  NREQ          one-hot grant; request i accepted this cycle
//  req_a      in   NREQ*WIDTH    operand a of requester i, slice [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH    operand b of requester i, same slicing
//  add_a      out  WIDTH         to adder input a
//  add_b      out  WIDTH         to adder input b
//  add_sum    in   WIDTH+1       from adder output out
//  rsp_valid  out  1             result held valid
//  rsp_ready  in   1             consumer accepts result
//  rsp_id     out  ID_W          index of requester owning the result
//  rsp_sum    out  WIDTH+1       registered sum, full carry, no truncation
//  busy       out  1             state != IDLE
//  op_cnt     out  8             completed responses, wraps 255->0
// BEHAVIOUR
//  Reset (async on rst_n=0), all values hold until the first post-reset clock:
//  - state=IDLE; rr_ptr=0; add_a=0; add_b=0; rsp_valid=0; rsp_id=0; rsp_sum=0; op_cnt=0.
//  - req_ready=0, busy=0.
//  FSM states: IDLE -> ADD -> RESP -> IDLE.
//  IDLE:
//  - If any req_valid: req_ready[g]=1 (combinational, only in IDLE), g = arbitration winner.
//  - At the edge: latch req_a[g] and req_b[g] into add_a/add_b, latch g into rsp_id, go to ADD.
//  - Round-robin: rr_ptr <= (g+1) mod NREQ at grant.
//  - If no req_valid: all req_ready=0, stay in IDLE.
//  ADD:
//  - add_a/add_b held stable. At the edge: rsp_sum <= add_sum, rsp_valid <= 1, go to RESP.
//  RESP:
//  - rsp_valid=1; rsp_id and rsp_sum are held stable until the handshake.
//  - On rsp_valid&&rsp_ready: rsp_valid <= 0, op_cnt <= op_cnt+1, go to IDLE.
//  - Otherwise stay in RESP (backpressure) with no new grants.
//  Latency and throughput:
//  - Grant at edge N; rsp_valid=1 after edge N+2.
//  - With rsp_ready=1, the next grant occurs in the cycle after the handshake, so one op every 3 cycles.
//  Arbitration (default, round-robin):
//  - Search from rr_ptr upward with wrap; the first asserted req_valid wins.
//  - With simultaneous requests, every active requester is served within NREQ grants.
//  Boundaries:
//  - req_valid deasserted before its grant: no effect, no response.
//  - req_valid of a requester held across its own response: the requester is re-arbitrated normally.
//  - Sum overflow: carry kept in bit WIDTH (15+12 -> 5'b11011).
//  - op_cnt wrap: 255+1 -> 0.
//  - rst_n asserted mid-operation: the in-flight op is discarded, no response is issued and all state resets.
//  - req_ready is never asserted outside IDLE; at most one bit is set.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined:
//  - Fixed priority: the lowest asserted index always wins; rr_ptr is unused and held at 0.
//  ARB_FIXED_PRIO_EN undefined (default):
//  - Round-robin as described under BEHAVIOUR.
// TESTING
//  1. Single op: req0 a=1 b=4 -> req_ready=4'b0001 in the grant cycle.
//     Then rsp_valid 2 cycles later with rsp_id=0, rsp_sum=5; op_cnt=1 after the handshake.
//  2. Carry: req2 a=15 b=12 -> rsp_sum=27 (5'b11011), rsp_id=2.
//     Also a=11 b=13 -> 24.
//  3. Round-robin contention: all 4 req_valid held, rsp_ready=1.
//     -> Grant order 0,1,2,3,0; responses spaced 3 cycles apart.
//     With ARB_FIXED_PRIO_EN, the same stimulus yields 0,0,0,...
//  4. Backpressure: rsp_ready=0 for 5 cycles, req1 a=7 b=6 -> rsp_valid held.
//     rsp_sum stays 13, no req_ready asserted, busy=1; release -> IDLE next cycle.
//  5. Reset mid-op: rst_n=0 while in ADD with a=9 b=9.
//     -> rsp_valid=0, rsp_sum=0, busy=0 immediately; no response issued after release.
//  6. Counter wrap: 256 completed ops (a=0 b=3, rsp_sum=3 each) -> op_cnt returns to 0.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request, adder and response signals of adder_share_arbiter
interface adder_share_arbiter_if #(parameter int WIDTH = 4, parameter int NREQ = 4);
  localparam int ID_W = $clog2(NREQ);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH:0] add_sum, rsp_sum;
  logic rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0] rsp_id;
  logic [7:0] op_cnt;
  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy, op_cnt
  );
  modport slave (
    input req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy, op_cnt
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one external adder among NREQ requesters, IDLE->ADD->RESP.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module adder_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ = 4
) (
  input logic clk,
  input logic rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t state_q;
  logic [ID_W-1:0] grant, cand, rsp_id_q;
  logic [WIDTH-1:0] sel_a, sel_b, add_a_q, add_b_q;
  logic [WIDTH:0] rsp_sum_q;
  logic rsp_valid_q;
  logic [7:0] op_cnt_q;
`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_q;
`endif
  // descending scan so the candidate nearest the search start is assigned last and wins
  always_comb begin
    grant = '0;
    cand = '0;
    sel_a = '0;
    sel_b = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      cand = ID_W'((int'(rr_q) + k) % NREQ);
`endif
      if (bus.req_valid[cand]) grant = cand;
    end
    for (int i = 0; i < NREQ; i++)
      if (ID_W'(i) == grant) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
  end
  assign bus.req_ready = (rst_n && state_q == IDLE && |bus.req_valid) ? NREQ'(1) << grant : '0;
  assign bus.add_a = add_a_q;
  assign bus.add_b = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_sum = rsp_sum_q;
  assign bus.busy = state_q != IDLE;
  assign bus.op_cnt = op_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
      rr_q <= '0;
`endif
      add_a_q <= '0;
      add_b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_sum_q <= '0;
      op_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req_valid) begin
          add_a_q <= sel_a;
          add_b_q <= sel_b;
          rsp_id_q <= grant;
`ifndef ARB_FIXED_PRIO_EN
          rr_q <= ID_W'((int'(grant) + 1) % NREQ);
`endif
          state_q <= ADD;
        end
        ADD: begin
          rsp_sum_q <= bus.add_sum;
          rsp_valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          op_cnt_q <= op_cnt_q + 8'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed stimulus with a reference arbiter model and response scoreboard
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rv;
  logic [3:0] a [4];
  logic [3:0] b [4];
  int errors = 0;
  int checks = 0;
  int m_state = 0;
  int m_rr = 0;
  logic [7:0] m_cnt = 8'd0;
  int npop = 0;
  int tcnt = 0;
  logic [6:0] sb [$];
  int grants [$];
  int grant_t [$];
  adder_share_arbiter_if #(.WIDTH(4), .NREQ(4)) ifc ();
  adder_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  assign ifc.req_valid = rv;
  assign ifc.req_a = {a[3], a[2], a[1], a[0]};
  assign ifc.req_b = {b[3], b[2], b[1], b[0]};
  assign ifc.add_sum = {1'b0, ifc.add_a} + {1'b0, ifc.add_b};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge against the model, then return just after the next posedge
  task automatic tick();
    int w;
    int gi;
    logic [3:0] er;
    logic [6:0] e;
    @(negedge clk);
    w = -1;
    gi = -1;
    er = '0;
    if (m_state == 0 && rst_n)
      for (int k = 3; k >= 0; k--) if (rv[(m_rr + k) % 4]) w = (m_rr + k) % 4;
    if (w >= 0) er = 4'(1) << w;
    chk("req_ready", 32'(ifc.req_ready), 32'(er));
    chk("busy", 32'(ifc.busy), 32'(m_state != 0));
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(m_state == 2));
    chk("op_cnt", 32'(ifc.op_cnt), 32'(m_cnt));
    if (w >= 0) begin
      sb.push_back({2'(w), 5'(a[w]) + 5'(b[w])});
      for (int k = 0; k < 4; k++) if (ifc.req_ready[k]) gi = k;
      grants.push_back(gi);
      grant_t.push_back(tcnt);
`ifndef ARB_FIXED_PRIO_EN
      m_rr = (w + 1) % 4;
`endif
      m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2 && ifc.rsp_ready) begin
      if (sb.size() == 0) chk("sb_empty", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(ifc.rsp_id), 32'(e[6:5]));
        chk("rsp_sum", 32'(ifc.rsp_sum), 32'(e[4:0]));
      end
      m_cnt = m_cnt + 8'd1;
      npop++;
      m_state = 0;
    end
    tcnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_order [5];
    int start;
    int n;
    rst_n = 1'b0;
    ifc.rsp_ready = 1'b1;
    rv = 4'b0001;
    for (int i = 0; i < 4; i++) begin a[i] = 4'd0; b[i] = 4'd0; end
    #2;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'(0));
    chk("rst_busy", 32'(ifc.busy), 32'(0));
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(ifc.rsp_id), 32'(0));
    chk("rst_rsp_sum", 32'(ifc.rsp_sum), 32'(0));
    chk("rst_add_a", 32'(ifc.add_a), 32'(0));
    chk("rst_add_b", 32'(ifc.add_b), 32'(0));
    chk("rst_op_cnt", 32'(ifc.op_cnt), 32'(0));
    rv = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single op
    a[0] = 4'd1; b[0] = 4'd4; rv = 4'b0001;
    tick();
    rv = 4'b0000;
    tick();
    chk("t1_sum", 32'(ifc.rsp_sum), 32'(5));
    chk("t1_id", 32'(ifc.rsp_id), 32'(0));
    tick();
    chk("t1_op_cnt", 32'(ifc.op_cnt), 32'(1));
    // carry
    a[2] = 4'd15; b[2] = 4'd12; rv = 4'b0100;
    tick();
    rv = 4'b0000;
    tick();
    chk("t2_sum", 32'(ifc.rsp_sum), 32'(27));
    chk("t2_id", 32'(ifc.rsp_id), 32'(2));
    tick();
    a[3] = 4'd11; b[3] = 4'd13; rv = 4'b1000;
    tick();
    rv = 4'b0000;
    tick();
    chk("t2b_sum", 32'(ifc.rsp_sum), 32'(24));
    tick();
    // contention
    for (int i = 0; i < 4; i++) begin a[i] = 4'(i + 1); b[i] = 4'(2 * i + 5); end
    grants.delete();
    grant_t.delete();
    rv = 4'b1111;
    n = 0;
    while (n < 40 && grants.size() < 5) begin tick(); n++; end
    rv = 4'b0000;
    chk("t3_grants", 32'(grants.size()), 32'(5));
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("t3_order", 32'(grants[i]), 32'(exp_order[i]));
    for (int i = 1; i < 5 && i < grant_t.size(); i++) chk("t3_spacing", 32'(grant_t[i] - grant_t[i-1]), 32'(3));
    repeat (3) tick();
    // backpressure
    ifc.rsp_ready = 1'b0;
    a[1] = 4'd7; b[1] = 4'd6; rv = 4'b0010;
    tick();
    rv = 4'b1000;
    tick();
    repeat (5) begin
      tick();
      chk("t4_sum_hold", 32'(ifc.rsp_sum), 32'(13));
      chk("t4_id_hold", 32'(ifc.rsp_id), 32'(1));
    end
    ifc.rsp_ready = 1'b1;
    tick();
    chk("t4_idle", 32'(ifc.busy), 32'(0));
    tick();
    rv = 4'b0000;
    repeat (3) tick();
    // reset mid-op
    a[0] = 4'd9; b[0] = 4'd9; rv = 4'b0001;
    tick();
    rv = 4'b0000;
    chk("t5_in_add", 32'(ifc.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(ifc.rsp_valid), 32'(0));
    chk("t5_rsp_sum", 32'(ifc.rsp_sum), 32'(0));
    chk("t5_busy", 32'(ifc.busy), 32'(0));
    chk("t5_op_cnt", 32'(ifc.op_cnt), 32'(0));
    sb.delete();
    m_state = 0;
    m_rr = 0;
    m_cnt = 8'd0;
    start = npop;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t5_no_rsp", 32'(npop - start), 32'(0));
    // counter wrap
    a[0] = 4'd0; b[0] = 4'd3; rv = 4'b0001;
    start = npop;
    n = 0;
    while (n < 2000 && npop - start < 256) begin tick(); n++; end
    rv = 4'b0000;
    chk("t6_ops", 32'(npop - start), 32'(256));
    chk("t6_wrap", 32'(ifc.op_cnt), 32'(0));
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
